// File: rtl/prog_loader.sv
// Boot loader: streams a length-prefixed byte image into instruction memory
// and holds the CPU in reset until the whole image has been written.
module prog_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

    state_t                state;
    logic [15:0]           n;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            byte_idx;
    logic [31:0]           word;
    logic [ADDR_WIDTH:0]   wl_inc;
    logic [15:0]           n_full;

    assign wl_inc = words_loaded + (ADDR_WIDTH+1)'(1);
    assign n_full = {in_data, n[7:0]};

    // in_ready is only high in LEN0/LEN1/DATA, so in_valid alone marks a transfer there
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            n            <= '0;
            addr         <= '0;
            byte_idx     <= '0;
            word         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state        <= LEN0;
                        in_ready     <= 1'b1;
                        words_loaded <= '0;
                        byte_idx     <= '0;
                        addr         <= '0;
                    end
                end
                LEN0: begin
                    if (in_valid) begin
                        n[7:0] <= in_data;
                        state  <= LEN1;
                    end
                end
                LEN1: begin
                    if (in_valid) begin
                        n[15:8] <= in_data;
                        if (n_full == 16'd0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (17'(n_full) > DEPTH) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (in_valid) begin
                        word[{byte_idx, 3'b000} +: 8] <= in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state     <= WRITE;
                            in_ready  <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= {in_data, word[23:0]};
                        end
                    end
                end
                WRITE: begin
                    mem_we       <= 1'b0;
                    addr         <= addr + ADDR_WIDTH'(1);
                    words_loaded <= wl_inc;
                    if (17'(wl_inc) == {1'b0, n}) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state    <= DATA;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state        <= LEN0;
                        done         <= 1'b0;
                        cpu_hold     <= 1'b1;
                        in_ready     <= 1'b1;
                        words_loaded <= '0;
                        byte_idx     <= '0;
                        addr         <= '0;
                    end
                end
                ERR: begin
                    if (start) begin
                        state        <= LEN0;
                        err          <= 1'b0;
                        in_ready     <= 1'b1;
                        words_loaded <= '0;
                        byte_idx     <= '0;
                        addr         <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed images, expected writes queued
// by the driver and checked by an independent write monitor.
module tb_prog_loader;

    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    int checks = 0;
    int errors = 0;
    wr_t exp_q[$];
    logic [7:0] img[$];

    prog_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            chk("ready_low_in_write", {63'd0, in_ready}, 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {60'd0, mem_addr}, {60'd0, e.a});
                chk("wr_data", {32'd0, mem_wdata}, {32'd0, e.d});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: in_ready stayed 0, needed 1");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_img(input bit gaps);
        foreach (img[i]) send_byte(img[i], gaps);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic basic_img();
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00};
        push(4'd0, 32'h0000_0013);
        push(4'd1, 32'h0010_0093);
    endtask

    task automatic check_finish(input string tag, input logic [AW:0] n);
        @(negedge clk);
        chk({tag, "_last_we"}, {63'd0, mem_we}, 64'd1);
        chk({tag, "_not_done_yet"}, {63'd0, done}, 64'd0);
        @(negedge clk);
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd0);
        chk({tag, "_words"}, {59'd0, words_loaded}, {59'd0, n});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
        chk({tag, "_mem_addr"}, {60'd0, mem_addr}, 64'd0);
        chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
        chk({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd1);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_err"}, {63'd0, err}, 64'd0);
        chk({tag, "_words"}, {59'd0, words_loaded}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        reset = 1'b1;

        pulse_start();
        basic_img();
        send_img(1'b0);
        check_finish("basic", 5'd2);

        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("done_ignores_bytes", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        chk("done_words_held", {59'd0, words_loaded}, 64'd2);

        pulse_start();
        @(negedge clk);
        chk("reload_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        chk("reload_done", {63'd0, done}, 64'd0);
        chk("reload_words_clr", {59'd0, words_loaded}, 64'd0);
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        push(4'd0, 32'hDEAD_BEEF);
        send_img(1'b0);
        check_finish("reload", 5'd1);

        pulse_start();
        img = '{8'h00, 8'h00};
        send_img(1'b0);
        @(negedge clk);
        chk("empty_done", {63'd0, done}, 64'd1);
        chk("empty_we", {63'd0, mem_we}, 64'd0);
        chk("empty_words", {59'd0, words_loaded}, 64'd0);

        pulse_start();
        img = '{8'h11, 8'h00};
        send_img(1'b0);
        @(negedge clk);
        chk("ovf_err", {63'd0, err}, 64'd1);
        chk("ovf_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        chk("ovf_in_ready", {63'd0, in_ready}, 64'd0);
        chk("ovf_done", {63'd0, done}, 64'd0);
        repeat (3) @(negedge clk);
        chk("ovf_err_held", {63'd0, err}, 64'd1);
        pulse_start();
        @(negedge clk);
        chk("ovf_err_clr", {63'd0, err}, 64'd0);
        img = '{8'h10, 8'h00};
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b0;
            b0 = 8'(i);
            img.push_back(b0);
            img.push_back(8'h11);
            img.push_back(8'h22);
            img.push_back(8'hC0 | b0);
            push(AW'(i), {8'hC0 | b0, 8'h22, 8'h11, b0});
        end
        send_img(1'b0);
        check_finish("full", 5'd16);

        pulse_start();
        basic_img();
        send_img(1'b1);
        check_finish("gaps", 5'd2);

        pulse_start();
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
        send_img(1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("midrst");
        reset = 1'b1;
        @(negedge clk);
        pulse_start();
        basic_img();
        send_img(1'b1);
        check_finish("after_rst", 5'd2);

        @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Synthesizable boot loader that streams a program image into the CPU's instruction memory. It holds the CPU in reset until the image is fully written. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues one word write per instruction. It sits between an external byte source (UART/host bridge) and the instruction-memory write port. It replaces simulation-only `$readmemh` loading in hardware builds.

## Interface
- ADDR_WIDTH, 10: instruction-memory word-address width; depth = 2**ADDR_WIDTH words.
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-low reset.
- start  input  1  begin a load; sampled in IDLE, DONE and ERR only.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready at the rising edge.
- mem_we  output  1  one-cycle instruction-memory write strobe.
- mem_addr  output  ADDR_WIDTH  word address of the write.
- mem_wdata  output  32  word to write.
- cpu_hold  output  1  drives the CPU's reset; high except in DONE.
- done  output  1  image fully loaded.
- err  output  1  header word count exceeded memory depth.
- words_loaded  output  ADDR_WIDTH+1  count of words written in the current load.

## Operation
- Stream format:
  - 2-byte header N (word count, little-endian, low byte first).
  - Then 4*N payload bytes; each word is little-endian (first byte goes to bits [7:0]).
- States: IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR.
- IDLE:
  - in_ready=0.
  - start=1 moves to LEN0, clearing words_loaded, the byte index and the address.
- LEN0: in_ready=1; on transfer, latch N[7:0] and move to LEN1.
- LEN1: in_ready=1; on transfer, latch N[15:8]. Next state, evaluated on the full 16-bit N:
  - N=0 goes to DONE.
  - N > 2**ADDR_WIDTH goes to ERR.
  - Otherwise goes to DATA.
- DATA:
  - in_ready=1.
  - Each transfer shifts the byte into lane byte_idx of the word register; byte_idx is a 2-bit counter.
  - The transfer with byte_idx=3 moves to WRITE.
- WRITE (exactly one cycle):
  - Outputs: mem_we=1, mem_addr=current address, mem_wdata=assembled word, in_ready=0.
  - At the end of the cycle, address and words_loaded increment.
  - If words_loaded+1 == N, go to DONE; else return to DATA.
- DONE:
  - done=1, cpu_hold=0, in_ready=0; further bytes are ignored (not accepted).
  - start=1 begins a new load: returns to LEN0 with cpu_hold=1 and done=0 from the next cycle.
- ERR:
  - err=1, cpu_hold=1, in_ready=0, no writes.
  - start=1 clears err and goes to LEN0.
- start is ignored in LEN0, LEN1, DATA and WRITE.
- Address arithmetic:
  - mem_addr is ADDR_WIDTH bits, unsigned.
  - N == 2**ADDR_WIDTH is legal: the final write uses address 2**ADDR_WIDTH-1, and the address wraps to 0 without a further write.
  - words_loaded is ADDR_WIDTH+1 bits so it can hold 2**ADDR_WIDTH.

## Timing
- Reset (reset=0 at a rising edge) forces, from the next cycle:
  - State IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, done=0, err=0, words_loaded=0.
- Reset overrides every state, including mid-word and the WRITE cycle; a partially assembled word is discarded.
- All outputs are registered or decoded from the registered state only; there is no combinational path from in_valid to in_ready.
- Write latency: mem_we asserts the cycle after the 4th byte of a word is accepted.
- Throughput: at most 4 bytes per 5 cycles.
- done, cpu_hold=0 (DONE) and ERR are entered the cycle after the last WRITE, or after the LEN1 transfer for N=0 / overflow.
- mem_addr and mem_wdata hold their last values outside WRITE; consumers qualify them with mem_we.
- in_valid may drop at any time; gaps stall the loader with no state change.

## Test plan
- Basic load:
  - Stimulus: start, bytes 02 00 13 00 00 00 93 00 10 00.
  - Required: mem_we at addr 0 with 0x00000013, then addr 1 with 0x00100093; done=1 and cpu_hold=0 one cycle after the second write; words_loaded=2.
- Empty image:
  - Stimulus: start, bytes 00 00.
  - Required: done=1 the cycle after the LEN1 transfer; mem_we never asserts; words_loaded=0.
- Overflow:
  - Stimulus: ADDR_WIDTH=4, header 11 00 (N=17).
  - Required: err=1, cpu_hold=1, in_ready=0, no writes; a subsequent start plus header 10 00 and 64 bytes fills addresses 0..15, then done=1.
- Backpressure/gaps:
  - Stimulus: the basic load with in_valid randomly deasserted.
  - Required: identical writes; in_ready=0 exactly during WRITE cycles; no byte lost or duplicated.
- Reset mid-load:
  - Stimulus: assert reset after 5 bytes of the basic load.
  - Required: all outputs at reset values the next cycle; a fresh full load then completes correctly.
- Reload from DONE:
  - Stimulus: pulse start in DONE.
  - Required: cpu_hold=1 and done=0 next cycle; the second image overwrites from address 0.
